// File: rtl/x3q_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : x3q_alu_pipe
// Description : Parametrised, handshaked ALU for the x3q datapath. It sits
//               between decode/register-read and writeback. One operation is
//               accepted on a valid/ready handshake. Result and flags are
//               registered and held until the consumer takes them.
//               Modes: ADD, SUB, AND, OR, XOR, SHL, SHR (logical) and MUL.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Configuration macro:
//   X3Q_ALU_MUL_EN - defined  : builds the iterative shift-add multiplier.
//                               MUL takes WIDTH cycles.
//                    undefined: mode 111 completes in one cycle with result 0.
// ----------------------------------------------------------------------------
// Ports:
//   clk            in   1      system clock, rising edge
//   reset          in   1      asynchronous, active-low reset
//   in_valid       in   1      a, b, mode valid this cycle
//   in_ready       out  1      block can accept an operation this cycle
//   a              in   WIDTH  operand A
//   b              in   WIDTH  operand B (bits [SHW-1:0] = shift amount)
//   mode           in   3      operation select
//   out_valid      out  1      result and flags valid
//   out_ready      in   1      consumer takes the result this cycle
//   result         out  WIDTH  registered result
//   equal_flag     out  1      a == b of the accepted operation
//   greater_a_flag out  1      a > b, unsigned
//   zero_flag      out  1      result == 0
//   carry_flag     out  1      carry / borrow / shift-out / MUL overflow
// ============================================================================
module x3q_alu_pipe #(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             equal_flag,
    output logic             greater_a_flag,
    output logic             zero_flag,
    output logic             carry_flag
);

    localparam logic [2:0] MODE_ADD = 3'b000;
    localparam logic [2:0] MODE_SUB = 3'b001;
    localparam logic [2:0] MODE_AND = 3'b010;
    localparam logic [2:0] MODE_OR  = 3'b011;
    localparam logic [2:0] MODE_XOR = 3'b100;
    localparam logic [2:0] MODE_SHL = 3'b101;
    localparam logic [2:0] MODE_SHR = 3'b110;
    localparam logic [2:0] MODE_MUL = 3'b111;

`ifdef X3Q_ALU_MUL_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OUT  = 2'd2
    } state_t;
`endif

    state_t             state_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   result_q;
    logic               equal_q;
    logic               greater_q;
    logic               zero_q;
    logic               carry_q;

    logic               accept;
    logic [SHW-1:0]     shamt;
    logic [WIDTH:0]     add_ext;
    logic [WIDTH:0]     shl_ext;
    logic [WIDTH:0]     shr_ext;
    logic [WIDTH-1:0]   alu_res_d;
    logic               alu_carry_d;

`ifdef X3Q_ALU_MUL_EN
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [SHW-1:0]     count_q;
    logic [2*WIDTH-1:0] acc_step_d;

    // One shift-add step: the multiplicand is pre-shifted to the current bit
    // position, so the step is a plain conditional add.
    assign acc_step_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif

    // A drain and a new accept may share an edge when the consumer is ready.
    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_OUT) && out_ready);
    assign accept   = in_valid && in_ready;

    // Upper bits of b are ignored for shifts.
    assign shamt   = b[SHW-1:0];
    assign add_ext = {1'b0, a} + {1'b0, b};
    // The extra bit above (SHL) or below (SHR) the operand catches the last
    // bit shifted out. It stays 0 for a zero shift amount.
    assign shl_ext = {1'b0, a} << shamt;
    assign shr_ext = {a, 1'b0} >> shamt;

    always_comb begin
        alu_res_d   = '0;
        alu_carry_d = 1'b0;
        case (mode)
            MODE_ADD: begin
                alu_res_d   = add_ext[WIDTH-1:0];
                alu_carry_d = add_ext[WIDTH];
            end
            MODE_SUB: begin
                alu_res_d   = a - b;
                alu_carry_d = (a < b);
            end
            MODE_AND: alu_res_d = a & b;
            MODE_OR:  alu_res_d = a | b;
            MODE_XOR: alu_res_d = a ^ b;
            MODE_SHL: begin
                alu_res_d   = shl_ext[WIDTH-1:0];
                alu_carry_d = shl_ext[WIDTH];
            end
            MODE_SHR: begin
                alu_res_d   = shr_ext[WIDTH:1];
                alu_carry_d = shr_ext[0];
            end
            // Single-cycle value for MUL when no multiplier is built.
            // With the multiplier present, this path is never registered.
            MODE_MUL: begin
                alu_res_d   = '0;
                alu_carry_d = 1'b0;
            end
            default: begin
                alu_res_d   = '0;
                alu_carry_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            equal_q     <= 1'b0;
            greater_q   <= 1'b0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
`ifdef X3Q_ALU_MUL_EN
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            count_q     <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_OUT: begin
                    if (accept) begin
                        // Comparison flags always come from the accepted operands.
                        equal_q   <= (a == b);
                        greater_q <= (a > b);
`ifdef X3Q_ALU_MUL_EN
                        if (mode == MODE_MUL) begin
                            state_q     <= ST_MUL;
                            out_valid_q <= 1'b0;
                            count_q     <= '0;
                            acc_q       <= '0;
                            mcand_q     <= {{WIDTH{1'b0}}, a};
                            mplier_q    <= b;
                        end else begin
`else
                        begin
`endif
                            state_q     <= ST_OUT;
                            out_valid_q <= 1'b1;
                            result_q    <= alu_res_d;
                            carry_q     <= alu_carry_d;
                            zero_q      <= (alu_res_d == '0);
                        end
                    end else if ((state_q == ST_OUT) && out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
`ifdef X3Q_ALU_MUL_EN
                ST_MUL: begin
                    acc_q    <= acc_step_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + SHW'(1);
                    // The last step result goes straight into the output
                    // registers. out_valid rises WIDTH edges after the accept.
                    if (count_q == SHW'(WIDTH - 1)) begin
                        state_q     <= ST_OUT;
                        out_valid_q <= 1'b1;
                        result_q    <= acc_step_d[WIDTH-1:0];
                        carry_q     <= |acc_step_d[2*WIDTH-1:WIDTH];
                        zero_q      <= (acc_step_d[WIDTH-1:0] == '0);
                        count_q     <= '0;
                    end
                end
`endif
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid      = out_valid_q;
    assign result         = result_q;
    assign equal_flag     = equal_q;
    assign greater_a_flag = greater_q;
    assign zero_flag      = zero_q;
    assign carry_flag     = carry_q;

endmodule
`default_nettype wire

// File: tb/tb_x3q_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_x3q_alu_pipe
// Description : Self-checking bench for x3q_alu_pipe (WIDTH=16).
//               Expected results are queued when an operation is driven.
//               They are popped and compared when the DUT hands over a result.
//               Directed checks cover latency, backpressure, holding and reset.
//               Honours X3Q_ALU_MUL_EN the same way the design does.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_x3q_alu_pipe;

    typedef struct packed {
        logic [15:0] res;
        logic        eq;
        logic        gt;
        logic        z;
        logic        c;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a_i = '0;
    logic [15:0] b_i = '0;
    logic [2:0]  mode_i = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic        equal_flag;
    logic        greater_a_flag;
    logic        zero_flag;
    logic        carry_flag;

    exp_t  sb[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    n_out = 0;
    int    n_exp = 0;

    x3q_alu_pipe #(.WIDTH(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .a              (a_i),
        .b              (b_i),
        .mode           (mode_i),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .result         (result),
        .equal_flag     (equal_flag),
        .greater_a_flag (greater_a_flag),
        .zero_flag      (zero_flag),
        .carry_flag     (carry_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t mk(input logic [15:0] r, input logic eq, input logic gt,
                                input logic z, input logic c);
        exp_t e;
        e.res = r; e.eq = eq; e.gt = gt; e.z = z; e.c = c;
        return e;
    endfunction

    // Independent reference model of one operation.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic [2:0] m);
        logic [31:0] wide;
        logic [15:0] r;
        logic        c;
        int          sh;
        sh = int'(y[3:0]);
        r  = '0;
        c  = 1'b0;
        case (m)
            3'd0: begin wide = {16'd0, x} + {16'd0, y}; r = wide[15:0]; c = wide[16]; end
            3'd1: begin r = x - y; c = (x < y); end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            3'd5: begin r = x << sh; c = (sh == 0) ? 1'b0 : x[16-sh]; end
            3'd6: begin r = x >> sh; c = (sh == 0) ? 1'b0 : x[sh-1]; end
            default: begin
`ifdef X3Q_ALU_MUL_EN
                wide = {16'd0, x} * {16'd0, y};
                r = wide[15:0];
                c = |wide[31:16];
`else
                r = '0;
                c = 1'b0;
`endif
            end
        endcase
        return mk(r, x == y, x > y, r == 16'd0, c);
    endfunction

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Scoreboard consumer: every handed-over result must match the oldest entry.
    always @(negedge clk) begin
        exp_t  obs;
        exp_t  e;
        string t;
        if (reset && out_valid && out_ready) begin
            obs = {result, equal_flag, greater_a_flag, zero_flag, carry_flag};
            n_checks++;
            if (sb.size() == 0) begin
                assert (sb.size() != 0) else begin
                    n_errors++;
                    $error("FAIL unexpected_output observed=%h expected=no output", obs);
                end
            end else begin
                e = sb.pop_front();
                t = tag_q.pop_front();
                n_out++;
                assert (obs === e) else begin
                    n_errors++;
                    $error("FAIL %s observed={res,eq,gt,z,c}=%h expected=%h", t, obs, e);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accept edge.
    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [2:0] m,
                        input exp_t e, input string tag);
        logic accepted;
        in_valid = 1'b1; a_i = x; b_i = y; mode_i = m;
        sb.push_back(e);
        tag_q.push_back(tag);
        n_exp++;
        accepted = 1'b0;
        for (int i = 0; i < 40 && !accepted; i++) begin
            @(negedge clk);
            if (in_ready) accepted = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check({tag, "_accept"}, 32'(accepted), 32'd1);
    endtask

    task automatic drop_last();
        void'(sb.pop_back());
        void'(tag_q.pop_back());
        n_exp--;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        check("drain", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [2:0]  rm;
        logic        saw;

        // Reset state, sampled while reset is held low.
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'({equal_flag, greater_a_flag, zero_flag, carry_flag}), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Directed operations with latency-1 checks.
        send(16'hFFFF, 16'h0001, 3'd0, mk(16'h0000, 0, 1, 1, 1), "add_wrap");
        @(negedge clk);
        check("add_latency", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        send(16'h0003, 16'h0005, 3'd1, mk(16'hFFFE, 0, 0, 0, 1), "sub_borrow");
        send(16'h8001, 16'h0001, 3'd5, mk(16'h0002, 0, 1, 0, 1), "shl_out");
        send(16'h8001, 16'h0001, 3'd6, mk(16'h4000, 0, 1, 0, 1), "shr_out");
        send(16'h1234, 16'h0010, 3'd5, mk(16'h1234, 0, 1, 0, 0), "shl_zero_amt");
        send(16'h00F0, 16'h0004, 3'd6, mk(16'h000F, 0, 1, 0, 0), "shr_4");
        send(16'h5A5A, 16'h5A5A, 3'd3, mk(16'h5A5A, 1, 0, 0, 0), "or_equal");
        send(16'h5A5A, 16'h5A5A, 3'd4, mk(16'h0000, 1, 0, 1, 0), "xor_zero");
`ifdef X3Q_ALU_MUL_EN
        send(16'h0007, 16'h0007, 3'd7, mk(16'h0031, 1, 0, 0, 0), "mul_7x7");
`else
        send(16'h0007, 16'h0007, 3'd7, mk(16'h0000, 1, 0, 1, 0), "mode7_off");
        @(negedge clk);
        check("mode7_latency", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
`endif
        wait_drain();

        // Back-to-back random operations, drain and accept on the same edge.
        for (int i = 0; i < 12; i++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
            rm = 3'($urandom_range(0, 7));
            send(ra, rb, rm, model(ra, rb, rm), "rnd");
        end
        wait_drain();

        // Backpressure: result held, in_ready low, then no bubble on release.
        out_ready = 1'b0;
        send(16'h0002, 16'h0003, 3'd0, mk(16'h0005, 0, 0, 0, 0), "bp_add");
        in_valid = 1'b1; a_i = 16'h00FF; b_i = 16'h0F0F; mode_i = 3'd4;
        sb.push_back(mk(16'h0FF0, 0, 0, 0, 0));
        tag_q.push_back("bp_xor");
        n_exp++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold_result", 32'(result), 32'h0005);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_no_bubble_valid", 32'(out_valid), 32'd1);
        check("bp_no_bubble_result", 32'(result), 32'h0FF0);
        @(posedge clk); #1;
        wait_drain();

`ifdef X3Q_ALU_MUL_EN
        // MUL latency: out_valid exactly 16 edges after accept.
        send(16'h0123, 16'h0010, 3'd7, mk(16'h1230, 0, 1, 0, 0), "mul_1230");
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            check("mul_valid_timing", 32'(out_valid), (k == 16) ? 32'd1 : 32'd0);
            if (k < 16) check("mul_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        send(16'h1000, 16'h0010, 3'd7, mk(16'h0000, 0, 1, 1, 1), "mul_overflow");
        wait_drain();

        // Reset mid-MUL: the aborted operation must never produce a result.
        send(16'h00FF, 16'h00FF, 3'd7, mk(16'hFE01, 1, 0, 0, 0), "mul_abort");
        repeat (5) @(posedge clk);
        #2 reset = 1'b0;
        drop_last();
        #1;
        check("mulrst_out_valid", 32'(out_valid), 32'd0);
        check("mulrst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            saw = saw | out_valid;
        end
        check("mulrst_no_stale", 32'(saw), 32'd0);
        @(posedge clk); #1;
`endif

        // Asynchronous reset while a result is held.
        out_ready = 1'b0;
        send(16'h2222, 16'h1111, 3'd0, mk(16'h3333, 0, 1, 0, 0), "rst_hold");
        @(negedge clk);
        check("rst_hold_valid", 32'(out_valid), 32'd1);
        #2 reset = 1'b0;
        drop_last();
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_result", 32'(result), 32'd0);
        check("async_rst_flags", 32'({equal_flag, greater_a_flag, zero_flag, carry_flag}), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("after_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        send(16'h00F0, 16'h0FF0, 3'd2, mk(16'h00F0, 0, 0, 0, 0), "and_after_rst");
        wait_drain();

        check("outputs_seen", 32'(n_out), 32'(n_exp));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
